// File: rtl/slm_msg_tx.sv
// slm_msg_tx: queues colour-detector events and streams each one as a
// 14-byte "SLM-FSU<n>-<cc>-#<TERM>" frame over a tx_start/tx_done handshake.
//
// Ports:
//   clk_3125  system clock, rising edge
//   rst       asynchronous active-high reset
//   color     detector code (0 none, 1 red, 2 green, 3 blue), level
//   tx_done   one-cycle pulse from the UART when a byte is finished
//   tx_start  one-cycle pulse launching the byte on tx_msg
//   tx_msg    byte to transmit, held until the next tx_start
//   busy      FSM not idle or event FIFO non-empty
//   fifo_full event FIFO is full
//   drop_cnt  saturating count of events lost to a full FIFO
module slm_msg_tx #(
    parameter int          NUM_FSU    = 3,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  TERM       = 8'h20
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic [1:0] color,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_msg,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0] LAST_IDX = 4'd13;
    localparam logic [3:0] NUM_C = 4'(NUM_FSU);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t        state;
    logic [1:0]    color_q;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    code_l;
    logic [3:0]    digit_l;
    logic [3:0]    fsu_idx;
    logic [3:0]    idx;
    logic          event_det;
    logic          pop;
    logic          push;
    logic [7:0]    frame_char;

    // A held colour fires once; a change to 0 never fires.
    assign event_det = (color != 2'd0) && (color != color_q);
    assign pop       = (state == IDLE) && (count != '0);
    assign fifo_full = (count == DEPTH_C);
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign push      = event_det && (!fifo_full || pop);
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            color_q  <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 8'h00;
        end else begin
            color_q <= color;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (event_det && !push && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (push)
            mem[wr_ptr] <= color;
    end

    always_comb begin
        frame_char = 8'h00;
        case (idx)
            4'd0:    frame_char = 8'h53;
            4'd1:    frame_char = 8'h4C;
            4'd2:    frame_char = 8'h4D;
            4'd3:    frame_char = 8'h2D;
            4'd4:    frame_char = 8'h46;
            4'd5:    frame_char = 8'h53;
            4'd6:    frame_char = 8'h55;
            4'd7:    frame_char = 8'h30 + {4'b0000, digit_l};
            4'd8:    frame_char = 8'h2D;
            4'd9:    frame_char = (code_l == 2'd2) ? 8'h41 : 8'h49;
            4'd10:   frame_char = (code_l == 2'd1) ? 8'h4D : 8'h53;
            4'd11:   frame_char = 8'h2D;
            4'd12:   frame_char = 8'h23;
            4'd13:   frame_char = TERM;
            default: frame_char = 8'h00;
        endcase
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_msg   <= 8'h00;
            idx      <= 4'd0;
            code_l   <= 2'd0;
            digit_l  <= 4'd1;
            fsu_idx  <= 4'd1;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        code_l  <= mem[rd_ptr];
                        digit_l <= fsu_idx;
                        idx     <= 4'd0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_msg   <= frame_char;
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            if (fsu_idx >= NUM_C)
                                fsu_idx <= 4'd1;
                            else
                                fsu_idx <= fsu_idx + 4'd1;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slm_msg_tx.sv
// tb_slm_msg_tx: randomized and directed stimulus for slm_msg_tx with a
// frame-level reference model feeding a byte scoreboard checked by a monitor.
module tb_slm_msg_tx;

    localparam int         NUM_FSU    = 3;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] TERM       = 8'h20;

    logic       clk_3125 = 1'b0;
    logic       rst;
    logic [1:0] color;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_msg;
    logic       busy;
    logic       fifo_full;
    logic [7:0] drop_cnt;

    slm_msg_tx #(
        .NUM_FSU   (NUM_FSU),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TERM      (TERM)
    ) dut (
        .clk_3125 (clk_3125),
        .rst      (rst),
        .color    (color),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_msg   (tx_msg),
        .busy     (busy),
        .fifo_full(fifo_full),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_3125 = ~clk_3125;

    int errors = 0;
    int checks = 0;
    int nbytes = 0;
    int uart_delay = 5;
    bit stretch = 0;
    bit spur = 0;
    logic [7:0] exp_q [$];

    // reference model state
    logic [1:0] prev_m = 2'd0;
    bit active_m = 0;
    int queued_m = 0;
    int drops_m = 0;
    int fsu_m = 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_frame(input logic [1:0] c);
        string s;
        string cc;
        cc = (c == 2'd1) ? "IM" : (c == 2'd2) ? "AS" : "IS";
        s = $sformatf("SLM-FSU%0d-%s-#", fsu_m, cc);
        for (int i = 0; i < 13; i++)
            exp_q.push_back(s[i]);
        exp_q.push_back(TERM);
        fsu_m = (fsu_m == NUM_FSU) ? 1 : fsu_m + 1;
    endtask

    // Valid while every burst fits inside the frame its first event starts.
    task automatic drive(input logic [1:0] c);
        @(posedge clk_3125);
        #1;
        color = c;
        if (c != 2'd0 && c != prev_m) begin
            if (!active_m) begin
                active_m = 1;
                model_frame(c);
            end else if (queued_m < FIFO_DEPTH) begin
                queued_m++;
                model_frame(c);
            end else if (drops_m < 255) begin
                drops_m++;
            end
        end
        prev_m = c;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 30000) begin
            @(posedge clk_3125);
            #1;
            n++;
        end
        check("idle_wait", 32'(n < 30000), 1);
        repeat (4) @(posedge clk_3125);
        #1;
        active_m = 0;
        queued_m = 0;
    endtask

    // UART model: answers each tx_start after uart_delay cycles.
    initial begin
        int cnt;
        int dur;
        cnt = -1;
        dur = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk_3125);
            if (rst) begin
                cnt = -1;
                dur = 0;
            end else begin
                if (dur > 0)
                    dur--;
                if (tx_start)
                    cnt = uart_delay;
                else if (cnt > 0)
                    cnt--;
                else if (cnt == 0) begin
                    dur = stretch ? 2 : 1;
                    cnt = -1;
                end
            end
            tx_done = (dur > 0) || spur;
        end
    end

    // Monitor: every tx_start pulse pops one expected byte.
    initial begin
        logic prev_start;
        logic [7:0] e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk_3125);
            if (rst) begin
                prev_start = 1'b0;
            end else begin
                if (tx_start) begin
                    nbytes++;
                    check("pulse_width", 32'(prev_start), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none",
                                 tx_msg);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(tx_msg), 32'(e));
                    end
                end
                prev_start = tx_start;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int k;
        logic [1:0] c;

        rst = 1'b1;
        color = 2'd0;
        repeat (3) @(posedge clk_3125);
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_msg", 32'(tx_msg), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk_3125);

        // held colour: one frame, latency E+2
        uart_delay = 5;
        drive(2'd2);
        repeat (3) @(negedge clk_3125);
        check("latency_early", 32'(tx_start), 0);
        @(negedge clk_3125);
        check("latency_e2", 32'(tx_start), 1);
        repeat (996) drive(2'd2);
        wait_idle();
        check("held_bytes", 32'(nbytes), 14);
        check("held_busy", 32'(busy), 0);

        // spurious tx_done in IDLE, then stretched tx_done (lands in SEND)
        drive(2'd0);
        spur = 1;
        @(posedge clk_3125);
        #1;
        spur = 0;
        repeat (3) @(posedge clk_3125);
        #1;
        check("spur_idle_busy", 32'(busy), 0);
        stretch = 1;
        repeat (3) drive(2'd1);
        drive(2'd0);
        repeat (3) drive(2'd3);
        drive(2'd0);
        repeat (3) drive(2'd2);
        drive(2'd0);
        drive(2'd1);
        drive(2'd0);
        wait_idle();
        stretch = 0;

        // direct 1 -> 3
        repeat (3) drive(2'd1);
        repeat (3) drive(2'd3);
        drive(2'd0);
        wait_idle();

        // overflow with a slow UART
        uart_delay = 200;
        base = nbytes;
        repeat (4) drive(2'd1);
        for (int i = 0; i < 7; i++)
            repeat (4) drive(2'(1 + ((i + 1) % 3)));
        check("ovf_fifo_full", 32'(fifo_full), 1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'(drops_m));
        drive(2'd0);
        wait_idle();
        check("ovf_frames", 32'(nbytes - base), 70);

        // saturate drop_cnt, then reset in the middle of a frame
        base = nbytes;
        for (int i = 0; i < 300; i++)
            drive((i % 2 == 0) ? 2'd1 : 2'd2);
        check("sat_drop_cnt", 32'(drop_cnt), 32'(drops_m));
        check("sat_fifo_full", 32'(fifo_full), 1);
        n = 0;
        while (!(tx_start && nbytes == base + 5) && n < 5000) begin
            @(posedge clk_3125);
            #1;
            n++;
        end
        check("byte6_wait", 32'(n < 5000), 1);
        rst = 1'b1;
        color = 2'd0;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_fifo_full", 32'(fifo_full), 0);
        exp_q.delete();
        prev_m = 2'd0;
        active_m = 0;
        queued_m = 0;
        drops_m = 0;
        fsu_m = 1;
        repeat (3) @(posedge clk_3125);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk_3125);
        #1;
        check("post_rst_quiet", 32'(nbytes), 32'(base + 5));
        uart_delay = 3;
        repeat (2) drive(2'd3);
        drive(2'd0);
        wait_idle();

        // randomized bursts
        for (int b = 0; b < 30; b++) begin
            uart_delay = $urandom_range(1, 6);
            stretch = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 7);
            for (int i = 0; i < k; i++) begin
                c = 2'($urandom_range(1, 3));
                if (c == color || $urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 2)) drive(2'd0);
                repeat ($urandom_range(1, 3)) drive(c);
            end
            wait_idle();
            check("rand_drop_cnt", 32'(drop_cnt), 32'(drops_m));
            check("rand_fifo_full", 32'(fifo_full), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slm_msg_tx.md
# slm_msg_tx

Parametrised status-message generator for the sorting line. It watches the colour-detector code and queues each new detection in an internal event FIFO, so detections arriving while a message is on the wire are not lost. Each queued event becomes the 14-character ASCII frame "SLM-FSU<n>-<cc>-#<TERM>", where the FSU index n is auto-incremented across NUM_FSU units. The frame is streamed one byte at a time into the UART transmitter over the tx_start/tx_done handshake.

## Interface
- NUM_FSU, 3, number of FSUs; legal range 1..9; the FSU digit cycles 1..NUM_FSU.
- FIFO_DEPTH, 4, event queue depth; power of two, at least 2.
- TERM, 8'h20, final frame character (space by default; 8'h0A allowed).
- clk_3125  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- color  in  2  detector code: 0 none, 1 red, 2 green, 3 blue; a level signal.
- tx_done  in  1  one-cycle pulse from the UART when the current byte is finished.
- tx_start  out  1  one-cycle pulse; launches the byte on tx_msg.
- tx_msg  out  8  byte to transmit; holds its value until the next tx_start.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_full  out  1  event FIFO is full.
- drop_cnt  out  8  count of dropped events; saturates at 255.

## Operation
- Event detection:
  - color_q is a register holding the previous cycle's color.
  - An event is generated when color != 0 and color != color_q. Consequences:
    - a held colour produces exactly one event;
    - a direct change 1->3 produces a new event;
    - a change to 0 produces no event.
- Event push:
  - Only the 2-bit code is pushed.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and drop_cnt increments, saturating at 8'hFF.
- Frame layout, bytes 0..13: 'S' 'L' 'M' '-' 'F' 'S' 'U' d '-' c0 c1 '-' '#' TERM.
  - d = 8'h30 + fsu_idx.
  - Code 1 gives "IM", code 2 gives "AS", code 3 gives "IS".
- FSU index:
  - fsu_idx resets to 1.
  - It is latched with the code when the frame starts.
  - It increments after the last byte's tx_done and wraps from NUM_FSU back to 1.
  - With NUM_FSU = 1 the digit is always '1'.
- FSM, with states IDLE, SEND and WAIT:
  - IDLE: if the FIFO is non-empty, pop it, latch the code and fsu_idx, set idx = 0 and go to SEND.
  - SEND: drive tx_msg <= frame[idx] and tx_start <= 1, then go to WAIT.
  - WAIT: drive tx_start <= 0.
    - On tx_done with idx == 13, go to IDLE and advance fsu_idx.
    - On tx_done otherwise, idx <= idx + 1 and go to SEND.
- tx_done is honoured only in WAIT; pulses in IDLE or SEND are ignored.
- A frame in progress always completes, whatever color does; colour changes only queue further events.
- Message characters are generated combinationally from idx, the latched code and the latched digit; there is no RAM.

## Timing
- Reset values:
  - tx_start 0, tx_msg 8'h00, busy 0, fifo_full 0, drop_cnt 0;
  - FSM in IDLE, FIFO empty, fsu_idx 1, color_q 0.
- Reset mid-frame aborts the frame immediately and flushes the FIFO. The first event after reset is reported as FSU1.
- Latency, where an event is detected at rising edge E:
  - the push happens at E;
  - the pop happens at E+1 (IDLE -> SEND);
  - tx_start is high with byte 'S' during the cycle after E+2.
- Per byte, from tx_done to the next tx_start there is exactly 2 cycles (WAIT -> SEND -> pulse).
- tx_start is high for exactly one cycle per byte, giving 14 pulses per frame.
- The FIFO occupancy, fifo_full and busy update on the same edge as the push or pop.
- A frame finishing and the FIFO being non-empty give back-to-back frames: the next pop happens one cycle after the return to IDLE.
- drop_cnt never wraps.

## Test plan
- Reset, then hold color = 2 for 1000 cycles, with a UART model answering tx_done 5 cycles after each tx_start:
  - exactly 14 bytes "SLM-FSU1-AS-# " are sent;
  - tx_start is first high at E+2;
  - busy returns to 0.
- Apply colors 1 -> 0 -> 3 -> 0 -> 2 with NUM_FSU = 3, then a fourth event 1:
  - frames are FSU1-IM, FSU2-IS, FSU3-AS, then FSU1-IM, in order.
- With FIFO_DEPTH = 4 and a slow UART (tx_done 200 cycles after tx_start), create 7 events during frame 1:
  - fifo_full asserts;
  - drop_cnt = 3;
  - 5 frames in total are sent.
- Raise color 1 -> 3 directly, with no 0 between:
  - two frames are sent: FSUn-IM, then FSUn+1-IS.
- Assert rst at byte 6 of a frame with 2 events queued:
  - tx_start drops immediately and no further bytes are sent;
  - drop_cnt = 0;
  - the next event produces FSU1.
- Pulse tx_done spuriously while in IDLE and in SEND:
  - idx does not advance and frame content is unchanged.
